// File: rtl/uart_mmio_pkg.sv
// Shared register offsets, STATUS bit positions and FSM state types for uart_mmio.
package uart_mmio_pkg;

    localparam logic [4:0] TXDATA_OFF  = 5'h00;
    localparam logic [4:0] RXDATA_OFF  = 5'h04;
    localparam logic [4:0] STATUS_OFF  = 5'h08;
    localparam logic [4:0] BAUDDIV_OFF = 5'h0C;
    localparam logic [4:0] CTRL_OFF    = 5'h10;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_EMPTY = 2;
    localparam int ST_RX_FULL  = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_OVR   = 5;
    localparam int ST_FRM_ERR  = 6;
    localparam int ST_TX_BUSY  = 7;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign dout    = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART: register file, TX serializer and RX deserializer around two byte FIFOs.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int DEFAULT_DIV = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] uart_addr_i,
    input  logic [DATA_WIDTH-1:0] uart_wdata_i,
    input  logic                  uart_write_i,
    input  logic                  uart_enable_i,
    output logic [DATA_WIDTH-1:0] uart_rdata_o,
    output logic                  uart_tx_o,
    input  logic                  uart_rx_i,
    output logic                  uart_irq_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [15:0] eff_div(input logic [15:0] v);
        return (v < 16'd4) ? 16'd4 : v;
    endfunction

    logic [15:0] baud_q;
    logic [3:0]  ctrl_q;
    logic        tx_ovf_q, rx_ovr_q, frame_err_q, irq_q;
    logic [DATA_WIDTH-1:0] rdata_q, rd_val;

    logic        mapped, acc_wr, acc_rd, sts_w1c;
    logic [4:0]  reg_off;
    logic        tx_push, tx_pop, tx_empty, tx_full, tx_busy;
    logic        rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]  tx_dout, rx_dout;
    logic [CW-1:0] tx_count, rx_count;
    logic        tx_ovf_set, rx_ovr_set, frame_err_set;
    logic [7:0]  status;

    tx_state_t   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_line_q, tx_line_d;

    rx_state_t   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [1:0]  rx_sync_q;
    logic        rx_prev_q, rx_s;

    logic        unused_bits;
    assign unused_bits = ^{uart_wdata_i[DATA_WIDTH-1:16], uart_addr_i[1:0], tx_count, rx_count};

    assign mapped  = uart_enable_i && (uart_addr_i[ADDR_WIDTH-1:5] == '0);
    assign reg_off = {uart_addr_i[4:2], 2'b00};
    assign acc_wr  = mapped && uart_write_i;
    assign acc_rd  = mapped && !uart_write_i;
    assign sts_w1c = acc_wr && (reg_off == STATUS_OFF);
    assign tx_push = acc_wr && (reg_off == TXDATA_OFF);
    assign rx_pop  = acc_rd && (reg_off == RXDATA_OFF) && !rx_empty;
    assign tx_ovf_set = tx_push && tx_full && !tx_pop;
    assign tx_busy = (tx_state_q != TX_IDLE);
    assign rx_s    = rx_sync_q[1];

    always_comb begin
        status              = '0;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_TX_OVF]   = tx_ovf_q;
        status[ST_RX_OVR]   = rx_ovr_q;
        status[ST_FRM_ERR]  = frame_err_q;
        status[ST_TX_BUSY]  = tx_busy;
    end

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(uart_wdata_i[7:0]),
        .dout(tx_dout), .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_shift_q),
        .dout(rx_dout), .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    always_comb begin
        rd_val = '0;
        if (acc_rd) begin
            case (reg_off)
                TXDATA_OFF:  rd_val[0] = tx_full;
                RXDATA_OFF:  if (!rx_empty) rd_val[8:0] = {1'b1, rx_dout};
                STATUS_OFF:  rd_val[7:0] = status;
                BAUDDIV_OFF: rd_val[15:0] = baud_q;
                CTRL_OFF:    rd_val[3:0] = ctrl_q;
                default:     rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_q      <= 16'(DEFAULT_DIV);
            ctrl_q      <= 4'h3;
            tx_ovf_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (acc_wr && reg_off == BAUDDIV_OFF) baud_q <= uart_wdata_i[15:0];
            if (acc_wr && reg_off == CTRL_OFF)    ctrl_q <= uart_wdata_i[3:0];
            // New events win over a same-cycle W1C so none is lost.
            tx_ovf_q    <= tx_ovf_set    | (tx_ovf_q    & ~(sts_w1c & uart_wdata_i[ST_TX_OVF]));
            rx_ovr_q    <= rx_ovr_set    | (rx_ovr_q    & ~(sts_w1c & uart_wdata_i[ST_RX_OVR]));
            frame_err_q <= frame_err_set | (frame_err_q & ~(sts_w1c & uart_wdata_i[ST_FRM_ERR]));
            if (uart_enable_i && !uart_write_i) rdata_q <= rd_val;
            irq_q <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty & ~tx_busy);
        end
    end

    assign uart_rdata_o = rdata_q;
    assign uart_irq_o   = irq_q;
    assign uart_tx_o    = tx_line_q;

    // TX: each state spans exactly tx_div_q clocks, counted down to zero.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_line_d = 1'b1;
                if (ctrl_q[0] && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                    tx_div_d   = eff_div(baud_q);
                    tx_cnt_d   = eff_div(baud_q) - 16'd1;
                    tx_shift_d = tx_dout;
                    tx_line_d  = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = tx_div_q - 16'd1;
                    tx_bit_d   = 3'd0;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d   = tx_div_q - 16'd1;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_line_d  = 1'b1;
                    end else begin
                        tx_bit_d  = tx_bit_q + 3'd1;
                        tx_line_d = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == 16'd0) begin
                    if (ctrl_q[0] && !tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_d = TX_START;
                        tx_div_d   = eff_div(baud_q);
                        tx_cnt_d   = eff_div(baud_q) - 16'd1;
                        tx_shift_d = tx_dout;
                        tx_line_d  = 1'b0;
                    end else begin
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX: first check at half a bit, then one sample per bit period.
    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_div_d      = rx_div_q;
        rx_shift_d    = rx_shift_q;
        rx_bit_d      = rx_bit_q;
        rx_push       = 1'b0;
        rx_ovr_set    = 1'b0;
        frame_err_set = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (ctrl_q[1] && rx_prev_q && !rx_s) begin
                    rx_state_d = RX_START;
                    rx_div_d   = eff_div(baud_q);
                    rx_cnt_d   = (eff_div(baud_q) >> 1) - 16'd1;
                end
            end
            RX_START: begin
                if (rx_cnt_q == 16'd0) begin
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_DATA;
                        rx_cnt_d   = rx_div_q - 16'd1;
                        rx_bit_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    rx_cnt_d   = rx_div_q - 16'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_state_d = RX_IDLE;
                    if (!rx_s)                    frame_err_set = 1'b1;
                    else if (rx_full && !rx_pop)  rx_ovr_set    = 1'b1;
                    else                          rx_push       = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_div_q   <= 16'(DEFAULT_DIV);
            tx_bit_q   <= '0;
            tx_line_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_div_q   <= 16'(DEFAULT_DIV);
            rx_bit_q   <= '0;
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_line_q  <= tx_line_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sync_q  <= {rx_sync_q[0], uart_rx_i};
            rx_prev_q  <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        tx_shift_q <= tx_shift_d;
        rx_shift_q <= rx_shift_d;
    end

endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
Memory-mapped UART peripheral that consumes the single-port UART request interface exported by the AXI subsystem (enable/write/addr/wdata, rdata back). Provides a TX FIFO and serializer, an RX deserializer with a FIFO, a programmable baud divider, status/control registers and a level interrupt. Sits directly downstream of the AXI-to-SRAM-style UART slave port at base 0x4000_0000, window 0x000-0xFFF.

Parameters:
ADDR_WIDTH, 12, width of the register address bus (byte address)
DATA_WIDTH, 32, width of the read/write data buses
FIFO_DEPTH, 16, entries in each of the TX and RX FIFOs (power of 2, >=2)
DEFAULT_DIV, 868, reset value of BAUDDIV (clocks per bit)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
uart_addr_i  in  ADDR_WIDTH  byte address of the access
uart_wdata_i  in  DATA_WIDTH  write data
uart_write_i  in  1  1 = write, 0 = read; qualified by uart_enable_i
uart_enable_i  in  1  access request, one access per asserted cycle
uart_rdata_o  out  DATA_WIDTH  read data, valid the cycle after a read request
uart_tx_o  out  1  serial transmit line, idle high
uart_rx_i  in  1  serial receive line, asynchronous
uart_irq_o  out  1  level interrupt, registered

Behaviour:
- One clock, clk. Reset is synchronous and active-high, port rst. No other clocks.
- Reset values: uart_tx_o=1, uart_rdata_o=0, uart_irq_o=0. Both FIFOs empty. BAUDDIV=DEFAULT_DIV. CTRL=0x3 (tx_en, rx_en set, irq enables clear). Sticky flags 0. TX and RX FSMs IDLE.
- Reset mid-frame aborts the frame. uart_tx_o is high the cycle after rst is sampled. Partial RX byte is discarded.
- Decode: uart_addr_i[11:5] must be 0, otherwise unmapped. Unmapped reads return 0 and unmapped writes are ignored. uart_addr_i[1:0] is ignored.
- Register map:
  - 0x00 TXDATA: W pushes wdata[7:0]. R returns {31'b0, tx_full}.
  - 0x04 RXDATA: R pops. Returns {23'b0, 1'b1, byte} if not empty, else 0 with no pop. W is ignored.
  - 0x08 STATUS (R; W1C on bits 4-6): [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full, [4] tx_overflow, [5] rx_overrun, [6] frame_err, [7] tx_busy.
  - 0x0C BAUDDIV (RW): [15:0]. The effective divisor is max(value,4). Upper bits read 0.
  - 0x10 CTRL (RW): [0] tx_en, [1] rx_en, [2] ie_rx, [3] ie_tx.
- Read latency is exactly 1 cycle. uart_rdata_o is registered and holds its value until the next read. The RX pop is committed in the request cycle.
- Write to TXDATA while full: byte dropped, tx_overflow set.
- A simultaneous RX-FSM push and RXDATA pop both take effect; the count is unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when tx_en and the TX FIFO is not empty. The FIFO is popped and the divisor latched on this transition.
  - Each state lasts exactly DIV clocks. DATA sends 8 bits LSB first. STOP drives 1.
  - STOP -> START back-to-back if the FIFO is not empty, else IDLE.
  - A BAUDDIV write mid-frame takes effect at the next frame.
  - Clearing tx_en mid-frame completes the current frame.
- RX path:
  - uart_rx_i passes through a 2-flop synchronizer.
  - RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synced 1->0 edge when rx_en.
  - At DIV/2 the line is checked: if it is high (false start), go back to IDLE; otherwise sample every DIV clocks, 8 data bits then the stop bit.
  - Stop bit = 0: frame_err set, byte discarded.
  - RX FIFO full at stop: byte discarded, rx_overrun set.
  - Back to IDLE after the stop sample.
- uart_irq_o <= (ie_rx & ~rx_empty) | (ie_tx & tx_empty & ~tx_busy), registered.
- Divider counter is 16-bit. It reloads at each bit boundary and never wraps past 0.

Decomposition:
- Package uart_mmio_pkg:
  - register offset localparams (TXDATA_OFF, RXDATA_OFF, STATUS_OFF, BAUDDIV_OFF, CTRL_OFF)
  - STATUS bit-index constants
  - enum typedefs tx_state_t and rx_state_t
- Sub-module uart_fifo: synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, pop, din, dout, empty, full, count. Instantiated twice (TX, RX) with WIDTH=8.
- TX/RX FSMs and the register file stay in uart_mmio.

Test Plan:
- Reset, then read all registers -> STATUS=0x05, BAUDDIV=868, CTRL=0x3, RXDATA=0, uart_tx_o=1, irq=0.
- BAUDDIV=8, write TXDATA=0xA5 -> uart_tx_o falls on the cycle after the FIFO pop; observed bits 0,1,0,1,0,0,1,0,1,1, each exactly 8 clocks (80 clocks total); then STATUS.tx_busy=0.
- BAUDDIV=8, write 17 bytes back-to-back while transmitter idle -> first byte popped immediately, remaining 16 fill FIFO, none dropped; 18th write sets STATUS[4]; frames are contiguous with no idle gap.
- BAUDDIV=8, drive 0x3C on uart_rx_i with CTRL.ie_rx=1 -> uart_irq_o rises after stop; RXDATA read returns 0x13C one cycle later; next read returns 0 and irq falls.
- Drive a frame with stop bit 0, then a 2-clock low glitch -> STATUS[6]=1, RX FIFO stays empty, no false byte; write 0x40 to STATUS clears it.
- Fill RX with 16 bytes, send a 17th -> STATUS[5]=1, reading 16 returns the original bytes in order; 17th absent.
